// File: rtl/rd_port_arbiter.sv
// Round-robin controller sharing one synchronous memory read port between
// requesters A and B, with one access in flight and a fixed read latency RD_LAT.
module rd_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_vld,
    output logic [DATA_W-1:0] a_data,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_vld,
    output logic [DATA_W-1:0] b_data,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);
    localparam logic       OWN_A    = 1'b0;
    localparam logic       OWN_B    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RET   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              winner_s;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic              mem_re_q, mem_re_d;

    // Winner selection: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        winner_s = OWN_A;
        if (a_req && b_req) begin
            winner_s = ~last_owner_q;
        end else if (b_req) begin
            winner_s = OWN_B;
        end else begin
            winner_s = OWN_A;
        end
    end

    // Next-state and registered-output decode for the access sequence.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        lat_cnt_d    = lat_cnt_q;
        mem_addr_d   = mem_addr_q;
        a_data_d     = a_data_q;
        b_data_d     = b_data_q;
        a_gnt_d      = 1'b0;
        b_gnt_d      = 1'b0;
        a_vld_d      = 1'b0;
        b_vld_d      = 1'b0;
        mem_re_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    owner_d    = winner_s;
                    mem_addr_d = (winner_s == OWN_B) ? b_addr : a_addr;
                    a_gnt_d    = (winner_s == OWN_A);
                    b_gnt_d    = (winner_s == OWN_B);
                    mem_re_d   = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    // Data is steered straight into the owner's port register so
                    // the other requester's last result stays untouched.
                    if (owner_q == OWN_B) begin
                        b_data_d = mem_rdata;
                        b_vld_d  = 1'b1;
                    end else begin
                        a_data_d = mem_rdata;
                        a_vld_d  = 1'b1;
                    end
                    state_d = ST_RET;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            ST_RET: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_A;
            last_owner_q <= OWN_B;
            lat_cnt_q    <= 2'd0;
            mem_addr_q   <= '0;
            a_data_q     <= '0;
            b_data_q     <= '0;
            a_gnt_q      <= 1'b0;
            b_gnt_q      <= 1'b0;
            a_vld_q      <= 1'b0;
            b_vld_q      <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            lat_cnt_q    <= lat_cnt_d;
            mem_addr_q   <= mem_addr_d;
            a_data_q     <= a_data_d;
            b_data_q     <= b_data_d;
            a_gnt_q      <= a_gnt_d;
            b_gnt_q      <= b_gnt_d;
            a_vld_q      <= a_vld_d;
            b_vld_q      <= b_vld_d;
            mem_re_q     <= mem_re_d;
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_vld    = a_vld_q;
    assign b_vld    = b_vld_q;
    assign a_data   = a_data_q;
    assign b_data   = b_data_q;
    assign mem_re   = mem_re_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Scoreboard bench for rd_port_arbiter: two instances (RD_LAT 1 and 3) driven by
// directed and random requesters, checked against a timeline model of each access.
module tb_rd_port_arbiter;

    typedef struct {
        int         dut;
        int         cyc;
        logic       port;
        logic [7:0] val;
    } evt_t;

    logic                 clk;
    logic                 rst_n;
    logic [1:0][1:0]      req;
    logic [1:0][1:0][7:0] addr;
    logic [1:0][7:0]      mem_rdata;
    wire  [1:0][1:0]      gnt;
    wire  [1:0][1:0]      vld;
    wire  [1:0][1:0][7:0] dat;
    wire  [1:0]           mem_re;
    wire  [1:0][7:0]      mem_addr;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         end_req = 1'b0;
    bit         mon_done = 1'b0;
    int         pol [2][2];
    int         gnt_cyc [2][2];
    int         last_owner [2];
    int         free_edge [2];
    int         grants_cnt [2];
    logic [7:0] mem [2][256];
    logic       pv [2][5];
    logic [7:0] pd [2][5];
    logic [7:0] exp_data [2][2];
    evt_t       gq [$];
    evt_t       vq [$];

    rd_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(req[0][0]), .a_addr(addr[0][0]), .a_gnt(gnt[0][0]), .a_vld(vld[0][0]), .a_data(dat[0][0]),
        .b_req(req[0][1]), .b_addr(addr[0][1]), .b_gnt(gnt[0][1]), .b_vld(vld[0][1]), .b_data(dat[0][1]),
        .mem_re(mem_re[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0])
    );

    rd_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .a_req(req[1][0]), .a_addr(addr[1][0]), .a_gnt(gnt[1][0]), .a_vld(vld[1][0]), .a_data(dat[1][0]),
        .b_req(req[1][1]), .b_addr(addr[1][1]), .b_gnt(gnt[1][1]), .b_vld(vld[1][1]), .b_data(dat[1][1]),
        .mem_re(mem_re[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int first_idx(input evt_t q[$], input int k);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].dut == k) return i;
        end
        return -1;
    endfunction

    // Memory with RD_LAT-cycle read delay; the bus carries junk except in the valid cycle.
    task automatic mem_drive();
        for (int k = 0; k < 2; k++) begin
            for (int i = lat(k); i > 0; i--) begin
                pv[k][i] = pv[k][i-1];
                pd[k][i] = pd[k][i-1];
            end
            pv[k][0] = mem_re[k];
            pd[k][0] = mem[k][mem_addr[k]];
            mem_rdata[k] = pv[k][lat(k)] ? pd[k][lat(k)] : 8'($urandom);
        end
    endtask

    // Requester behaviour: 0 manual, 1 drop on grant, 2 renew on grant, 3 random.
    task automatic react(input int k, input int p);
        if (gnt_cyc[k][p] == cyc) begin
            case (pol[k][p])
                2: addr[k][p] = 8'($urandom);
                3: begin
                    if ($urandom_range(0, 3) == 0) addr[k][p] = 8'($urandom);
                    else req[k][p] = 1'b0;
                end
                default: req[k][p] = 1'b0;
            endcase
        end else if (pol[k][p] == 3) begin
            if (!req[k][p]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req[k][p]  = 1'b1;
                    addr[k][p] = 8'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req[k][p] = 1'b0;
            end
        end
    endtask

    // Reference model: decides what the coming clock edge does to each arbiter.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit   w;
            evt_t e;
            if (rst_n && (cyc + 1) >= free_edge[k] && (req[k][0] || req[k][1])) begin
                w = (req[k][0] && req[k][1]) ? (last_owner[k] == 0) : req[k][1];
                e.dut = k; e.port = w;
                e.cyc = cyc + 1;          e.val = addr[k][w];          gq.push_back(e);
                e.cyc = cyc + 2 + lat(k); e.val = mem[k][addr[k][w]];  vq.push_back(e);
                free_edge[k]  = cyc + 4 + lat(k);
                last_owner[k] = int'(w);
                gnt_cyc[k][w] = cyc + 1;
                grants_cnt[k]++;
            end
        end
    endtask

    task automatic edge_begin();
        @(negedge clk);
        mem_drive();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) react(k, p);
        end
    endtask

    task automatic edge_end();
        model_step();
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            edge_begin();
            edge_end();
        end
    endtask

    task automatic quiesce();
        edge_begin();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                req[k][p] = 1'b0;
                pol[k][p] = 0;
            end
        end
        edge_end();
        cycles(12);
    endtask

    task automatic purge_from(input int c);
        for (int i = gq.size() - 1; i >= 0; i--) if (gq[i].cyc >= c) gq.delete(i);
        for (int i = vq.size() - 1; i >= 0; i--) if (vq[i].cyc >= c) vq.delete(i);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues every cycle.
    initial begin : monitor
        int   gi;
        int   vi;
        logic w;
        forever begin
            @(negedge clk);
            #1;
            if (end_req) break;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    checks++;
                    if (gnt[k] != 2'b00 || vld[k] != 2'b00 || mem_re[k] != 1'b0 ||
                        mem_addr[k] != 8'h00 || dat[k] != 16'h0000) begin
                        failures++;
                        $display("FAIL reset_clear dut%0d cyc=%0d gnt=%b vld=%b re=%b addr=%h data=%h required all zero",
                                 k, cyc, gnt[k], vld[k], mem_re[k], mem_addr[k], dat[k]);
                    end
                    exp_data[k][0] = 8'h00;
                    exp_data[k][1] = 8'h00;
                end else begin
                    gi = first_idx(gq, k);
                    if (gi >= 0 && gq[gi].cyc == cyc) begin
                        w = gq[gi].port;
                        checks++;
                        if (mem_re[k] != 1'b1 || gnt[k][w] != 1'b1 || gnt[k][!w] != 1'b0 ||
                            mem_addr[k] != gq[gi].val) begin
                            failures++;
                            $display("FAIL grant dut%0d cyc=%0d got gnt=%b re=%b addr=%h required port=%0d re=1 addr=%h",
                                     k, cyc, gnt[k], mem_re[k], mem_addr[k], w, gq[gi].val);
                        end
                        gq.delete(gi);
                    end else if (gnt[k] != 2'b00 || mem_re[k] != 1'b0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant dut%0d cyc=%0d got gnt=%b re=%b required none",
                                 k, cyc, gnt[k], mem_re[k]);
                    end
                    vi = first_idx(vq, k);
                    if (vi >= 0 && vq[vi].cyc == cyc) begin
                        w = vq[vi].port;
                        checks++;
                        if (vld[k][w] != 1'b1 || vld[k][!w] != 1'b0 || dat[k][w] != vq[vi].val ||
                            dat[k][!w] != exp_data[k][!w]) begin
                            failures++;
                            $display("FAIL valid dut%0d cyc=%0d got vld=%b data=%h/%h required port=%0d data=%h other=%h",
                                     k, cyc, vld[k], dat[k][0], dat[k][1], w, vq[vi].val, exp_data[k][!w]);
                        end
                        exp_data[k][w] = vq[vi].val;
                        vq.delete(vi);
                    end else if (vld[k] != 2'b00) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid dut%0d cyc=%0d got vld=%b required none", k, cyc, vld[k]);
                    end
                end
            end
        end
        checks++;
        if (gq.size() != 0) begin
            failures++;
            $display("FAIL grants_outstanding got %0d pending required 0", gq.size());
        end
        checks++;
        if (vq.size() != 0) begin
            failures++;
            $display("FAIL valids_outstanding got %0d pending required 0", vq.size());
        end
        mon_done = 1'b1;
    end

    initial begin
        rst_n     = 1'b1;
        req       = '0;
        addr      = '0;
        mem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            last_owner[k] = 1;
            free_edge[k]  = 0;
            grants_cnt[k] = 0;
            for (int p = 0; p < 2; p++) begin
                pol[k][p]      = 0;
                gnt_cyc[k][p]  = -1;
                exp_data[k][p] = 8'h00;
            end
            for (int i = 0; i < 5; i++) begin
                pv[k][i] = 1'b0;
                pd[k][i] = 8'h00;
            end
            for (int a = 0; a < 256; a++) mem[k][a] = 8'($urandom);
        end
        mem[0][8'h12] = 8'h34;
        mem[1][8'h7F] = 8'hA5;
        #2 rst_n = 1'b0;
        cycles(2);

        // Tie after reset: both requesters held, expect A,B,A,B.
        edge_begin();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            free_edge[k]  = cyc + 1;
            grants_cnt[k] = 0;
            for (int p = 0; p < 2; p++) begin
                pol[k][p]  = 2;
                req[k][p]  = 1'b1;
                addr[k][p] = 8'($urandom);
            end
        end
        edge_end();
        for (int i = 0; i < 100 && grants_cnt[1] < 4; i++) cycles(1);
        quiesce();

        // Single reads: A at 0x12 on the latency-1 port, B at 0x7F on the latency-3 port.
        edge_begin();
        req[0][0] = 1'b1; addr[0][0] = 8'h12; pol[0][0] = 1;
        req[1][1] = 1'b1; addr[1][1] = 8'h7F; pol[1][1] = 1;
        edge_end();
        cycles(12);

        // B request pulse while an A access on the latency-1 port is waiting.
        edge_begin();
        req[0][0] = 1'b1; addr[0][0] = 8'($urandom); pol[0][0] = 1;
        edge_end();
        for (int i = 0; i < 20; i++) begin
            edge_begin();
            if (cyc == gnt_cyc[0][0] + 1) begin
                req[0][1] = 1'b1; addr[0][1] = 8'($urandom);
                edge_end();
                break;
            end
            edge_end();
        end
        edge_begin();
        req[0][1] = 1'b0;
        edge_end();
        cycles(10);

        // Reset in the middle of an access, then a tie that A must win.
        edge_begin();
        for (int k = 0; k < 2; k++) begin
            req[k][0] = 1'b1; addr[k][0] = 8'($urandom); pol[k][0] = 1;
        end
        edge_end();
        for (int i = 0; i < 20; i++) begin
            edge_begin();
            if (cyc == gnt_cyc[0][0] + 1) begin
                rst_n = 1'b0;
                purge_from(cyc);
                for (int k = 0; k < 2; k++) begin
                    last_owner[k] = 1;
                    free_edge[k]  = 32'h7fff_ffff;
                    for (int p = 0; p < 2; p++) begin
                        req[k][p] = 1'b0;
                        pol[k][p] = 0;
                    end
                end
                edge_end();
                break;
            end
            edge_end();
        end
        cycles(1);
        edge_begin();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            free_edge[k] = cyc + 1;
            for (int p = 0; p < 2; p++) begin
                req[k][p] = 1'b1; addr[k][p] = 8'($urandom); pol[k][p] = 1;
            end
        end
        edge_end();
        cycles(20);
        quiesce();

        // Continuous A with the address changed at every grant.
        edge_begin();
        for (int k = 0; k < 2; k++) begin
            grants_cnt[k] = 0;
            req[k][0] = 1'b1; addr[k][0] = 8'($urandom); pol[k][0] = 2;
        end
        edge_end();
        for (int i = 0; i < 200 && (grants_cnt[0] < 5 || grants_cnt[1] < 5); i++) cycles(1);
        quiesce();

        // Random traffic including withdrawn and renewed requests.
        edge_begin();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) pol[k][p] = 3;
        end
        edge_end();
        cycles(800);
        quiesce();

        end_req = 1'b1;
        wait (mon_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
